// File: rtl/mac_pkg.sv
// Shared types and helpers for the multi-lane MAC pipeline.
//   MODE_MAC / MODE_ACC : per-beat mode encoding
//   ctrl_t              : control bundle that travels alongside the lane data
//   sat_add()           : signed add with clamp to an acc_width-bit range
package mac_pkg;

   localparam logic MODE_MAC = 1'b0;
   localparam logic MODE_ACC = 1'b1;

   // Widest accumulator the saturating adder supports (AccWidth must be < SAT_W).
   localparam int SAT_W = 64;

   typedef struct packed {
      logic nop;
      logic mode;
      logic clear;
      logic last;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{nop: 1'b1, mode: MODE_MAC, clear: 1'b0, last: 1'b0};

   typedef struct packed {
      logic signed [SAT_W-1:0] sum;
      logic                    ovf;
   } sat_res_t;

   // Operands are sign-extended acc_width values; the sum is formed one bit wider
   // than SAT_W so it can never wrap before the clamp compare.
   function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                        input logic signed [SAT_W-1:0] b,
                                        input int unsigned             acc_width);
      logic signed [SAT_W:0] s;
      logic signed [SAT_W:0] one;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      sat_res_t              r;
      one    = '0;
      one[0] = 1'b1;
      s      = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
      hi     = (one <<< (acc_width - 1)) - one;
      lo     = -(one <<< (acc_width - 1));
      if (s > hi) begin
         r.sum = hi[SAT_W-1:0];
         r.ovf = 1'b1;
      end else if (s < lo) begin
         r.sum = lo[SAT_W-1:0];
         r.ovf = 1'b1;
      end else begin
         r.sum = s[SAT_W-1:0];
         r.ovf = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: multiply pipe, O alignment pipe, accumulator, saturation and
// the trailing pure-delay add stages.
//   clk, rst                : clock, async active-high reset
//   w_data, i_data, o_data  : lane operands, captured every cycle
//   add_nop/mode/clear      : control for the beat currently at the add stage
//   result, sat             : lane result and clamp flag after the full latency
module mac_lane
   import mac_pkg::*;
#(
   parameter int DataWidth = 16,
   parameter int AccWidth  = 40,
   parameter int MulStages = 2,
   parameter int AddStages = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [DataWidth-1:0] w_data,
   input  logic signed [DataWidth-1:0] i_data,
   input  logic signed [AccWidth-1:0]  o_data,
   input  logic                        add_nop,
   input  logic                        add_mode,
   input  logic                        add_clear,
   output logic signed [AccWidth-1:0]  result,
   output logic                        sat
);

   logic signed [2*DataWidth-1:0] prod_full;
   logic signed [AccWidth-1:0]    prod_ext;
   logic signed [AccWidth-1:0]    prod_q [MulStages];
   logic signed [AccWidth-1:0]    o_q    [MulStages];
   logic signed [AccWidth-1:0]    acc_q;
   logic signed [AccWidth-1:0]    base;
   logic signed [AccWidth-1:0]    data_q [AddStages];
   logic        [AddStages-1:0]   sat_q;
   sat_res_t                      res;
   logic signed [AccWidth-1:0]    res_trunc;
   logic                          unused_res_hi;

   assign prod_full = w_data * i_data;
   assign prod_ext  = {{(AccWidth-2*DataWidth){prod_full[2*DataWidth-1]}}, prod_full};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < MulStages; k++) begin
            prod_q[k] <= '0;
            o_q[k]    <= '0;
         end
      end else begin
         prod_q[0] <= prod_ext;
         o_q[0]    <= o_data;
         for (int k = 1; k < MulStages; k++) begin
            prod_q[k] <= prod_q[k-1];
            o_q[k]    <= o_q[k-1];
         end
      end
   end

   // ACC without clear continues from the accumulator; MAC and ACC+clear start from O.
   always_comb begin
      base = (add_mode == MODE_ACC && !add_clear) ? acc_q : o_q[MulStages-1];
      res  = sat_add({{(SAT_W-AccWidth){base[AccWidth-1]}}, base},
                     {{(SAT_W-AccWidth){prod_q[MulStages-1][AccWidth-1]}}, prod_q[MulStages-1]},
                     AccWidth);
   end

   assign res_trunc     = res.sum[AccWidth-1:0];
   assign unused_res_hi = ^res.sum[SAT_W-1:AccWidth];

   // Stage 0 holds on NOP, so a bubble re-presents the previous result downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         sat_q <= '0;
         for (int k = 0; k < AddStages; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         if (!add_nop) begin
            data_q[0] <= res_trunc;
            sat_q[0]  <= res.ovf;
            if (add_mode == MODE_ACC) begin
               acc_q <= res_trunc;
            end
         end
         for (int k = 1; k < AddStages; k++) begin
            data_q[k] <= data_q[k-1];
            sat_q[k]  <= sat_q[k-1];
         end
      end
   end

   assign result = data_q[AddStages-1];
   assign sat    = sat_q[AddStages-1];

endmodule

// File: rtl/mac_pipeline_multilane.sv
// Lanes-wide signed fixed-point MAC/accumulate pipeline with fixed latency
// Pipeline_Stages and one beat per cycle.
//   clk, rst                  : clock, async active-high reset
//   NOPIn, Mode, ClearIn,
//   LastIn                    : per-beat control shared by all lanes
//   W_Data, I_Data, O_Data    : packed per-lane operands
//   NOPOut, LastOut           : control delayed by the pipeline latency
//   SatOut, DataOut           : per-lane clamp flags and packed results
module mac_pipeline_multilane
   import mac_pkg::*;
#(
   parameter int DataWidth           = 16,
   parameter int AccWidth            = 40,
   parameter int Lanes               = 4,
   parameter int MUL_Pipeline_Stages = 2,
   parameter int ADD_Pipeline_Stages = 1,
   parameter int Pipeline_Stages     = MUL_Pipeline_Stages + ADD_Pipeline_Stages
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      NOPIn,
   input  logic                      Mode,
   input  logic                      ClearIn,
   input  logic                      LastIn,
   input  logic [Lanes*DataWidth-1:0] W_Data,
   input  logic [Lanes*DataWidth-1:0] I_Data,
   input  logic [Lanes*AccWidth-1:0]  O_Data,
   output logic                      NOPOut,
   output logic                      LastOut,
   output logic [Lanes-1:0]          SatOut,
   output logic [Lanes*AccWidth-1:0] DataOut
);

   ctrl_t ctrl_in;
   ctrl_t ctrl_q [Pipeline_Stages];

   // A bubble carries no mode/clear/last so nothing downstream can act on it.
   always_comb begin
      ctrl_in.nop   = NOPIn;
      ctrl_in.mode  = Mode    & ~NOPIn;
      ctrl_in.clear = ClearIn & ~NOPIn;
      ctrl_in.last  = LastIn  & ~NOPIn;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < Pipeline_Stages; k++) begin
            ctrl_q[k] <= CTRL_IDLE;
         end
      end else begin
         ctrl_q[0] <= ctrl_in;
         for (int k = 1; k < Pipeline_Stages; k++) begin
            ctrl_q[k] <= ctrl_q[k-1];
         end
      end
   end

   for (genvar l = 0; l < Lanes; l++) begin : g_lane
      mac_lane #(
         .DataWidth (DataWidth),
         .AccWidth  (AccWidth),
         .MulStages (MUL_Pipeline_Stages),
         .AddStages (ADD_Pipeline_Stages)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .w_data    (W_Data[l*DataWidth +: DataWidth]),
         .i_data    (I_Data[l*DataWidth +: DataWidth]),
         .o_data    (O_Data[l*AccWidth +: AccWidth]),
         .add_nop   (ctrl_q[MUL_Pipeline_Stages-1].nop),
         .add_mode  (ctrl_q[MUL_Pipeline_Stages-1].mode),
         .add_clear (ctrl_q[MUL_Pipeline_Stages-1].clear),
         .result    (DataOut[l*AccWidth +: AccWidth]),
         .sat       (SatOut[l])
      );
   end

   assign NOPOut  = ctrl_q[Pipeline_Stages-1].nop;
   assign LastOut = ctrl_q[Pipeline_Stages-1].last;

endmodule

// File: tb/tb_mac_pipeline_multilane.sv
module tb_mac_pipeline_multilane;

   localparam int LAT = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         NOPIn = 1'b1;
   logic         Mode = 1'b0;
   logic         ClearIn = 1'b0;
   logic         LastIn = 1'b0;
   logic [63:0]  W_Data = '0;
   logic [63:0]  I_Data = '0;
   logic [159:0] O_Data = '0;
   logic         NOPOut;
   logic         LastOut;
   logic [3:0]   SatOut;
   logic [159:0] DataOut;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int           due;
      logic         nop;
      logic         last;
      logic [159:0] data;
      logic [3:0]   sat;
      logic [3:0]   mask;
      string        name;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   mac_pipeline_multilane dut (
      .clk     (clk),
      .rst     (rst),
      .NOPIn   (NOPIn),
      .Mode    (Mode),
      .ClearIn (ClearIn),
      .LastIn  (LastIn),
      .W_Data  (W_Data),
      .I_Data  (I_Data),
      .O_Data  (O_Data),
      .NOPOut  (NOPOut),
      .LastOut (LastOut),
      .SatOut  (SatOut),
      .DataOut (DataOut)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic signed [39:0] MAXV = 40'sh7F_FFFF_FFFF;
   localparam logic signed [39:0] MINV = 40'sh80_0000_0000;

   function automatic logic [63:0] pw(input int l, input int v);
      logic [63:0] r;
      r = '0;
      r[l*16 +: 16] = 16'(v);
      return r;
   endfunction

   function automatic logic [159:0] po(input int l, input logic signed [39:0] v);
      logic [159:0] r;
      r = '0;
      r[l*40 +: 40] = v;
      return r;
   endfunction

   task automatic issue(input string nm, input logic nop, input logic mode, input logic clr,
                        input logic last, input logic [63:0] w, input logic [63:0] i,
                        input logic [159:0] o, input logic [159:0] ed, input logic [3:0] es,
                        input logic [3:0] mask);
      exp_t x;
      @(posedge clk);
      #1;
      NOPIn = nop; Mode = mode; ClearIn = clr; LastIn = last;
      W_Data = w; I_Data = i; O_Data = o;
      x.due = cyc + LAT; x.nop = nop; x.last = last & ~nop;
      x.data = ed; x.sat = es; x.mask = mask; x.name = nm;
      sb.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         NOPIn = 1'b1; Mode = 1'b0; ClearIn = 1'b0; LastIn = 1'b0;
      end
   endtask

   task automatic check_reset_state(input string nm);
      checks++;
      if (NOPOut !== 1'b1 || LastOut !== 1'b0 || SatOut !== 4'b0 || DataOut !== '0) begin
         failures++;
         $display("FAIL %s: nop=%b last=%b sat=%b data=%h, required nop=1 last=0 sat=0 data=0",
                  nm, NOPOut, LastOut, SatOut, DataOut);
      end
   endtask

   // Monitor: compare whenever a scheduled beat reaches the outputs.
   always @(negedge clk) begin
      if (!rst && sb.size() > 0) begin
         if (sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (NOPOut !== e.nop || LastOut !== e.last) begin
               failures++;
               $display("FAIL %s flags: nop=%b last=%b, required nop=%b last=%b",
                        e.name, NOPOut, LastOut, e.nop, e.last);
            end
            for (int l = 0; l < 4; l++) begin
               if (e.mask[l]) begin
                  checks++;
                  if (DataOut[l*40 +: 40] !== e.data[l*40 +: 40] || SatOut[l] !== e.sat[l]) begin
                     failures++;
                     $display("FAIL %s lane%0d: data=%0d sat=%b, required data=%0d sat=%b",
                              e.name, l, $signed(DataOut[l*40 +: 40]), SatOut[l],
                              $signed(e.data[l*40 +: 40]), e.sat[l]);
                  end
               end
            end
         end else if (sb[0].due < cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: result slot missed at cycle %0d, required at %0d", e.name, cyc, e.due);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset_initial");
      rst = 1'b0;

      // MAC on lane0
      issue("mac0_a", 0, 0, 0, 0, pw(0, 15), pw(0, 4), po(0, 40), po(0, 100), 4'b0000, 4'b0001);
      issue("mac0_b", 0, 0, 0, 0, pw(0, 100), pw(0, 200), po(0, 1000), po(0, 21000), 4'b0000, 4'b0001);

      // ACC sequence on lane1, with a bubble in the middle
      issue("acc1_clr", 0, 1, 1, 0, pw(1, 2), pw(1, 3), po(1, 40'sd10), po(1, 40'sd16), 4'b0000, 4'b0010);
      issue("acc1_sub", 0, 1, 0, 0, pw(1, -1), pw(1, 5), '0, po(1, 40'sd11), 4'b0000, 4'b0010);
      issue("acc1_nop", 1, 1, 1, 1, pw(1, 77), pw(1, 77), po(1, 40'sd99), po(1, 40'sd11), 4'b0000, 4'b0010);
      issue("acc1_last", 0, 1, 0, 1, pw(1, 4), pw(1, 4), '0, po(1, 40'sd27), 4'b0000, 4'b0010);

      // Saturation on lane2
      issue("sat2_pos", 0, 1, 1, 0, pw(2, 1), pw(2, 1), po(2, MAXV), po(2, MAXV), 4'b0100, 4'b0100);
      issue("sat2_back", 0, 1, 0, 0, pw(2, -1), pw(2, 1), '0, po(2, MAXV - 40'sd1), 4'b0000, 4'b0100);
      issue("sat2_neg", 0, 1, 1, 0, pw(2, -1), pw(2, 1), po(2, MINV), po(2, MINV), 4'b0100, 4'b0100);

      // Mode interleave on lane3
      issue("mix3_seed", 0, 1, 1, 0, pw(3, 0), pw(3, 0), po(3, 40'sd5), po(3, 40'sd5), 4'b0000, 4'b1000);
      issue("mix3_mac", 0, 0, 0, 0, pw(3, 3), pw(3, 3), po(3, 40'sd1), po(3, 40'sd10), 4'b0000, 4'b1000);
      issue("mix3_acc", 0, 1, 0, 0, pw(3, 1), pw(3, 1), po(3, 40'sd123), po(3, 40'sd6), 4'b0000, 4'b1000);

      // Async reset with a saturated/last beat on the outputs and more in flight
      issue("pre_rst", 0, 1, 1, 1, pw(0, 1), pw(0, 1), po(0, MAXV), po(0, MAXV), 4'b0001, 4'b0001);
      issue("inflight_a", 0, 0, 0, 0, pw(0, 1), pw(0, 1), po(0, 40'sd1), po(0, 40'sd2), 4'b0000, 4'b0001);
      issue("inflight_b", 0, 0, 0, 1, pw(0, 2), pw(0, 2), po(0, 40'sd1), po(0, 40'sd5), 4'b0000, 4'b0001);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      #1;
      check_reset_state("reset_async_inflight");
      idle(2);
      rst = 1'b0;

      // All lanes distinct
      issue("lanes_mac", 0, 0, 0, 0,
            pw(0, -7) | pw(1, 1000) | pw(2, 32767) | pw(3, -32768),
            pw(0, 9) | pw(1, -1000) | pw(2, 32767) | pw(3, -32768),
            po(0, 40'sd3) | po(1, 40'sd0) | po(2, -40'sd1) | po(3, 40'sd100),
            po(0, -40'sd60) | po(1, -40'sd1000000) | po(2, 40'sd1073676288) | po(3, 40'sd1073741924),
            4'b0000, 4'b1111);
      issue("lanes_seed", 0, 1, 1, 0,
            {4{16'd2}}, {4{16'd2}},
            po(0, 40'sd10) | po(1, 40'sd20) | po(2, 40'sd30) | po(3, 40'sd40),
            po(0, 40'sd14) | po(1, 40'sd24) | po(2, 40'sd34) | po(3, 40'sd44),
            4'b0000, 4'b1111);
      idle(LAT + 1);

      // Reset mid-accumulation: the next non-clear ACC starts from 0
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("reset_mid_acc");
      idle(1);
      rst = 1'b0;
      issue("post_rst_acc", 0, 1, 0, 0, {4{16'd2}}, {4{16'd2}},
            po(0, 40'sd99) | po(1, 40'sd99) | po(2, 40'sd99) | po(3, 40'sd99),
            po(0, 40'sd4) | po(1, 40'sd4) | po(2, 40'sd4) | po(3, 40'sd4),
            4'b0000, 4'b1111);

      for (int k = 0; k < 50 && sb.size() > 0; k++) idle(1);
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
